// File: rtl/matrix_add_streamer.sv
// Element-serial R x C signed-magnitude matrix adder with a valid/ready output stream.
// Optional MADD_OVF_FLAG_EN adds a sticky ovf flag and a per-element ovf_elem flag.
`ifndef N
`define N 32
`endif

module matrix_add_streamer #(
    parameter int unsigned R  = 6,
    parameter int unsigned C  = 6,
    parameter int unsigned RW = (R > 1) ? $clog2(R) : 1,
    parameter int unsigned CW = (C > 1) ? $clog2(C) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [`N-1:0]     a [0:R-1][0:C-1],
    input  logic [`N-1:0]     b [0:R-1][0:C-1],
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [`N-1:0]     out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic              done
`ifdef MADD_OVF_FLAG_EN
    ,
    output logic              ovf,
    output logic              ovf_elem
`endif
);

    localparam int unsigned W  = `N;
    localparam int unsigned MW = W - 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_buf [0:R-1][0:C-1];
    logic [W-1:0]  b_buf [0:R-1][0:C-1];
    logic [RW-1:0] i_q, ni_c, sel_i_c;
    logic [CW-1:0] j_q, nj_c, sel_j_c;
    logic          last_c, next_last_c, accept_c;
    logic [W-1:0]  sum_c;

    // Saturating signed-magnitude add; zero is always returned as +0.
    function automatic logic [W-1:0] sm_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [MW:0]   s;
        logic [MW-1:0] m;
        logic          sg;
        s  = '0;
        m  = '0;
        sg = 1'b0;
        if (x[W-1] == y[W-1]) begin
            s  = {1'b0, x[MW-1:0]} + {1'b0, y[MW-1:0]};
            m  = s[MW] ? '1 : s[MW-1:0];
            sg = x[W-1];
        end else if (x[MW-1:0] >= y[MW-1:0]) begin
            m  = x[MW-1:0] - y[MW-1:0];
            sg = x[W-1];
        end else begin
            m  = y[MW-1:0] - x[MW-1:0];
            sg = y[W-1];
        end
        if (m == '0) sg = 1'b0;
        return {sg, m};
    endfunction

    function automatic logic sm_sat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [MW:0] s;
        s = {1'b0, x[MW-1:0]} + {1'b0, y[MW-1:0]};
        return (x[W-1] == y[W-1]) && s[MW];
    endfunction

    // Index sequencing: LOAD reads (i,j) itself, STREAM reads the successor.
    always_comb begin
        last_c = (i_q == RW'(R - 1)) && (j_q == CW'(C - 1));
        if (j_q == CW'(C - 1)) begin
            nj_c = '0;
            ni_c = i_q + RW'(1);
        end else begin
            nj_c = j_q + CW'(1);
            ni_c = i_q;
        end
        next_last_c = (ni_c == RW'(R - 1)) && (nj_c == CW'(C - 1));
        sel_i_c     = (state_q == S_LOAD) ? i_q : ni_c;
        sel_j_c     = (state_q == S_LOAD) ? j_q : nj_c;
        sum_c       = sm_add(a_buf[sel_i_c][sel_j_c], b_buf[sel_i_c][sel_j_c]);
        accept_c    = out_valid && out_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (accept_c && last_c) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            for (int r = 0; r < int'(R); r++) begin
                for (int c = 0; c < int'(C); c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_q == S_STREAM) && (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_buf <= a;
                        b_buf <= b;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                S_LOAD: begin
                    out_data  <= sum_c;
                    out_valid <= 1'b1;
                    out_last  <= last_c;
                end
                S_STREAM: begin
                    if (accept_c) begin
                        if (last_c) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            i_q      <= ni_c;
                            j_q      <= nj_c;
                            out_data <= sum_c;
                            out_last <= next_last_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_row = i_q;
    assign out_col = j_q;

`ifdef MADD_OVF_FLAG_EN
    logic sat_c;
    assign sat_c = sm_sat(a_buf[sel_i_c][sel_j_c], b_buf[sel_i_c][sel_j_c]);

    // ovf is sticky across DONE/IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            ovf_elem <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) ovf <= 1'b0;
                S_LOAD: begin
                    ovf_elem <= sat_c;
                    if (sat_c) ovf <= 1'b1;
                end
                S_STREAM: begin
                    if (accept_c) begin
                        if (last_c) begin
                            ovf_elem <= 1'b0;
                        end else begin
                            ovf_elem <= sat_c;
                            if (sat_c) ovf <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`else
    // Saturation still applies in sm_add; only the flag outputs are absent.
`endif

endmodule

// File: tb/tb_matrix_add_streamer.sv
// Directed self-checking bench for matrix_add_streamer (default build, 6x6, 32-bit elements).
module tb_matrix_add_streamer;
    localparam int R = 6;
    localparam int C = 6;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [31:0] a [0:R-1][0:C-1];
    logic [31:0] b [0:R-1][0:C-1];
    logic        busy, out_valid, out_last, done;
    logic [31:0] out_data;
    logic [2:0]  out_row;
    logic [2:0]  out_col;

    logic [31:0] exp_m [0:R-1][0:C-1];
    int tests = 0;
    int fails = 0;

    matrix_add_streamer #(.R(R), .C(C)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [31:0] av, input logic [31:0] bv);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                a[r][c] = av;
                b[r][c] = bv;
            end
    endtask

    task automatic set_exp(input logic [31:0] ev);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) exp_m[r][c] = ev;
    endtask

    // Pulse start and check the two-cycle start-to-valid latency.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("lat_busy", busy, 1);
        check("lat_valid_k", out_valid, 0);
        step();
        check("lat_valid_k1", out_valid, 1);
        check("first_row", out_row, 0);
        check("first_col", out_col, 0);
    endtask

    // Consume the stream, checking order, values, hold under backpressure and done.
    task automatic stream(input bit bp, input bit disturb);
        int n = 0;
        int cyc = 0;
        bit fin = 0;
        bit pend = 0;
        logic [31:0] pd;
        logic [2:0] pr, pc;
        while (!fin && cyc < 400) begin
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (pend) begin
                check("hold_data", out_data, pd);
                check("hold_row", out_row, pr);
                check("hold_col", out_col, pc);
            end
            check("valid_high", out_valid, 1);
            check("elem_data", out_data, exp_m[n / C][n % C]);
            check("elem_row", out_row, 32'(n / C));
            check("elem_col", out_col, 32'(n % C));
            check("elem_last", out_last, (n == R * C - 1) ? 1 : 0);
            pend = out_valid && !out_ready;
            pd = out_data;
            pr = out_row;
            pc = out_col;
            if (out_valid && out_ready) begin
                n++;
                if (n == R * C) fin = 1;
            end
            if (disturb && cyc == 5) begin
                set_ab(32'h0000_7777, 32'h0000_1111);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("handshakes", n, R * C);
        check("done_pulse", done, 1);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 1);
        step();
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        set_ab(32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);

        // e + pi
        set_ab(32'h0005_6FC2, 32'h0006_487E);
        set_exp(32'h000B_B840);
        do_start();
        stream(0, 0);

        // e + (-pi), then swapped operands
        set_ab(32'h0005_6FC2, 32'h8006_487E);
        set_exp(32'h8000_D8BC);
        do_start();
        stream(0, 0);
        set_ab(32'h8006_487E, 32'h0005_6FC2);
        do_start();
        stream(0, 0);

        // Positive saturation at (2,3)
        set_ab(32'h0, 32'h0);
        a[2][3] = 32'h7FFF_FFFF;
        b[2][3] = 32'h0000_0001;
        set_exp(32'h0);
        exp_m[2][3] = 32'h7FFF_FFFF;
        do_start();
        stream(0, 0);

        // Cancellation and -0 + -0 both give +0
        set_ab(32'h0000_0001, 32'h0000_0002);
        set_exp(32'h0000_0003);
        a[1][1] = 32'h0000_1000;
        b[1][1] = 32'h8000_1000;
        a[4][5] = 32'h8000_0000;
        b[4][5] = 32'h8000_0000;
        exp_m[1][1] = 32'h0;
        exp_m[4][5] = 32'h0;
        do_start();
        stream(0, 0);

        // Backpressure with operand change and stray start mid-stream
        set_ab(32'h0005_6FC2, 32'h0006_487E);
        set_exp(32'h000B_B840);
        do_start();
        stream(1, 1);

        // Reset mid-stream at row 3, then a fresh stream
        set_ab(32'h0000_0100, 32'h0000_0200);
        do_start();
        for (k = 0; k < 40; k++) begin
            if (out_row == 3'd3) break;
            step();
        end
        check("row3_reached", out_row, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_row", out_row, 0);
        check("mid_rst_col", out_col, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_done", done, 0);
        step();
        check("mid_rst_no_done", done, 0);
        check("mid_rst_idle", busy, 0);
        set_ab(32'h0000_0010, 32'h8000_0030);
        set_exp(32'h8000_0020);
        do_start();
        stream(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matrix_add_streamer.md
Name: matrix_add_streamer

Overview:
- Sequential counterpart to the combinational matrix adder. On a start pulse it captures two R x C operand matrices, adds them element by element with a single shared signed-magnitude adder, and streams the results out row-major over a valid/ready interface.
- Sits between the operand-producing stage and any downstream element-serial consumer, such as the activation unit or a result FIFO.

Parameters:
- R, 6, number of matrix rows.
- C, 6, number of matrix columns.
- Element width is the global `N from config.svh (default 32): signed magnitude, MSB is the sign, 17 fraction bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to capture a and b; honoured only in IDLE.
- a  in  `N x R x C  operand matrix A (unpacked [0:R-1][0:C-1]).
- b  in  `N x R x C  operand matrix B (unpacked [0:R-1][0:C-1]).
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  out_data/out_row/out_col/out_last are valid.
- out_ready  in  1  consumer accepts the current element.
- out_data  out  `N  a[i][j] + b[i][j], signed magnitude, saturated.
- out_row  out  $clog2(R)  row index i of out_data.
- out_col  out  $clog2(C)  column index j of out_data.
- out_last  out  1  high with element [R-1][C-1].
- done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, done=0. Index counters are cleared and captured buffers are discarded. Reset mid-stream aborts with no done pulse.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: if start=1 at edge k, register all of a and b into internal buffers; index (i,j)=(0,0); go to LOAD.
- LOAD: register sum[0][0] into out_data; set out_valid=1; go to STREAM. The first element is valid after edge k+1, so start-to-valid latency is 2 cycles.
- STREAM, on out_valid && out_ready:
  - Not last element: advance j; on j=C-1 wrap j to 0 and increment i. Register the next sum in the same edge; out_valid stays 1. Throughput is 1 element/cycle under continuous ready.
  - Last element: out_valid=0, go to DONE.
- STREAM, out_ready=0: out_data, indices and out_last hold stable (AXI-style; valid never drops without acceptance).
- DONE: done=1 for exactly one cycle; then IDLE, busy=0.
- start is ignored in LOAD, STREAM and DONE. Input changes after capture have no effect on the current stream.
- Signed-magnitude add, with ma, mb the magnitudes (N-1 bits):
  - Equal signs: m = ma + mb. If carry out, m = all ones (saturate). Sign is the common sign.
  - Different signs: the larger magnitude minus the smaller; sign is that of the larger magnitude.
  - Zero result is always emitted as +0 (0x00000000), including -0 + -0.
- out_last = (i==R-1 && j==C-1) whenever out_valid=1; 0 otherwise.
- R=1 or C=1 are legal; the index wrap still applies.

Optional Feature:
- Macro MADD_OVF_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit), a sticky flag. It is set in the cycle a saturated element is registered, cleared on rst or on an accepted start, and held through DONE and IDLE.
  - Adds output ovf_elem (1 bit), aligned with out_data and high when that element saturated.
- When undefined: both ports are absent; saturation behaviour is identical.

Test Plan:
- All a=0x00056FC2 (e), all b=0x0006487E (pi), out_ready=1, pulse start -> out_valid at cycle +2. 36 consecutive elements of 0x000BB840 in row-major order, out_last on the 36th, done one cycle later, no ovf.
- All a=0x00056FC2, all b=0x8006487E -> every element is 0x8000D8BC. Swap operands -> same result.
- a[2][3]=0x7FFFFFFF, b[2][3]=0x00000001, all others 0 -> element (2,3) is 0x7FFFFFFF and all others 0x00000000. With MADD_OVF_FLAG_EN, ovf_elem pulses at (2,3) and ovf stays 1 until the next start.
- a=0x00001000 with b=0x80001000 in one element, and a=b=0x80000000 in another -> both emit 0x00000000.
- Backpressure: toggle out_ready in a 1-0-0-1 pattern and change a/b, and pulse start, mid-stream -> out_data/out_row/out_col stable while ready is low. Streamed values come from the captured operands, the extra start is ignored, and exactly 36 handshakes occur.
- Assert rst while out_row=3 -> next cycle all outputs are 0 with no done pulse. A following start streams fresh data from (0,0).
